matrix_scroller: RTL and testbench



---
 rtl/matrix_scroller.sv | 134 +++++++++++++
 tb/tb_matrix_scroller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scroller.sv
// matrix_scroller: column-buffer pattern source for the 8x4 LED matrix driver.
// Presents a sliding 4-column window (data) that advances one column every
// FRAMES_PER_STEP frame_tick pulses and dwells at position 0 after each wrap.
// Optional build macro MATRIX_SCROLLER_DIR_EN adds a dir input (1 = reverse).
module matrix_scroller #(
  parameter int DEPTH           = 16,
  parameter int FRAMES_PER_STEP = 8,
  parameter int DWELL_STEPS     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic                     restart,
`ifdef MATRIX_SCROLLER_DIR_EN
  input  logic                     dir,
`endif
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_col,
  output logic [31:0]              data,
  output logic [$clog2(DEPTH)-1:0] pos,
  output logic                     step
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);

  typedef enum logic {SCROLL, DWELL} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0][7:0]  colbuf_q, colbuf_d;
  logic [31:0]            data_q, data_d;
  logic [AW-1:0]          pos_q, pos_d, pos_step;
  logic                   step_q, step_d;
  logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]          dwell_cnt_q, dwell_cnt_d;
  logic [3:0][7:0]        win;
  logic                   step_evt;

  // Window lanes: lane k shows column (pos+k) mod DEPTH; AW-bit add wraps.
  for (genvar k = 0; k < 4; k++) begin : g_win
    assign win[k] = colbuf_q[pos_q + AW'(k)];
  end

  assign step_evt = frame_tick && enable && (frame_cnt_q == FRAME_LAST);

  // Candidate position for a step event (direction sampled at the event).
`ifdef MATRIX_SCROLLER_DIR_EN
  assign pos_step = dir ? (pos_q - 1'b1) : (pos_q + 1'b1);
`else
  assign pos_step = pos_q + 1'b1;
`endif

  // Buffer write and frame-synchronous data reload from pre-edge contents.
  always_comb begin
    colbuf_d = colbuf_q;
    if (wr_en) colbuf_d[wr_addr] = wr_col;
    data_d = frame_tick ? win : data_q;
  end

  // Frame counter: counts enabled frame_ticks, wraps on the step event.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (restart)                  frame_cnt_d = '0;
    else if (frame_tick && enable) frame_cnt_d = step_evt ? '0 : frame_cnt_q + 1'b1;
  end

  // FSM next state: restart wins, otherwise only step events move the FSM.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = (DWELL_STEPS > 0) ? DWELL : SCROLL;
    end else if (step_evt) begin
      case (state_q)
        SCROLL:  if (pos_step == '0 && DWELL_STEPS > 0) state_d = DWELL;
        DWELL:   if (dwell_cnt_q == DWELL_LAST) state_d = SCROLL;
        default: state_d = SCROLL;
      endcase
    end
  end

  // FSM outputs: position, step pulse and dwell counter.
  always_comb begin
    pos_d       = pos_q;
    step_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    if (restart) begin
      pos_d       = '0;
      dwell_cnt_d = '0;
    end else if (step_evt) begin
      if (state_q == SCROLL) begin
        pos_d       = pos_step;
        step_d      = 1'b1;
        dwell_cnt_d = '0;
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SCROLL;
    else        state_q <= state_d;
  end

  // Datapath registers; reset also overrides a coincident buffer write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      colbuf_q    <= '0;
      data_q      <= '0;
      pos_q       <= '0;
      step_q      <= 1'b0;
      frame_cnt_q <= '0;
      dwell_cnt_q <= '0;
    end else begin
      colbuf_q    <= colbuf_d;
      data_q      <= data_d;
      pos_q       <= pos_d;
      step_q      <= step_d;
      frame_cnt_q <= frame_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign data = data_q;
  assign pos  = pos_q;
  assign step = step_q;

endmodule

// File: tb/tb_matrix_scroller.sv
// Directed bench for matrix_scroller (DEPTH=8, FRAMES_PER_STEP=2, DWELL_STEPS=1).
// Expected window words are queued when a frame_tick is driven and popped
// when the registered data word is sampled after the edge.
module tb_matrix_scroller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        dir = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_col = '0;
  logic [31:0] data;
  logic [2:0]  pos;
  logic        step;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [7:0]  mbuf [8];
  logic [2:0]  mpos;
  logic        mf;
  logic        mdwell;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  matrix_scroller #(.DEPTH(8), .FRAMES_PER_STEP(2), .DWELL_STEPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .restart(restart),
`ifdef MATRIX_SCROLLER_DIR_EN
    .dir(dir),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_col(wr_col),
    .data(data), .pos(pos), .step(step)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] win(input logic [2:0] p);
    logic [2:0] a0, a1, a2, a3;
    a0 = p; a1 = p + 3'd1; a2 = p + 3'd2; a3 = p + 3'd3;
    return {mbuf[a3], mbuf[a2], mbuf[a1], mbuf[a0]};
  endfunction

  // one clock; inputs were set away from the edge, sampled #1 after it
  task automatic clk1();
    @(posedge clk); #1;
    frame_tick = 1'b0; wr_en = 1'b0; restart = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
    mpos = '0; mf = 1'b0; mdwell = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_col = c;
    clk1();
    mbuf[a] = c;
  endtask

  // drive one frame_tick (plus any preset wr_en/restart), check data/pos/step
  task automatic frame();
    logic es;
    logic [31:0] got;
    es = 1'b0;
    exp_q.push_back(win(mpos));
    if (restart) begin
      mpos = '0; mf = 1'b0; mdwell = 1'b1;
    end else if (enable) begin
      if (mf) begin
        mf = 1'b0;
        if (!mdwell) begin
          mpos = dir ? mpos - 3'd1 : mpos + 3'd1;
          es = 1'b1;
          if (mpos == 3'd0) mdwell = 1'b1;
        end else begin
          mdwell = 1'b0;
        end
      end else begin
        mf = 1'b1;
      end
    end
    if (wr_en) mbuf[wr_addr] = wr_col;
    frame_tick = 1'b1;
    clk1();
    if (exp_q.size() == 0) begin
      compared++; mismatched++;
      $error("FAIL sb_empty: observed no entry expected one");
    end else begin
      got = exp_q.pop_front();
      chk("data", data, got);
    end
    chk("pos", {29'd0, pos}, {29'd0, mpos});
    chk("step", {31'd0, step}, {31'd0, es});
    clk1();
    chk("step_clr", {31'd0, step}, 32'd0);
  endtask

  task automatic run_to(input logic [2:0] p);
    int n;
    n = 0;
    while (mpos != p && n < 40) begin frame(); n++; end
    if (mpos != p) begin
      compared++; mismatched++;
      $error("FAIL run_to: observed pos %0d expected %0d", mpos, p);
    end
  endtask

  initial begin
    model_reset();
    // 1. reset state, fill buffer, first window
    clk1(); clk1();
    chk("rst_data", data, 32'h0);
    chk("rst_pos", {29'd0, pos}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    rst_n = 1'b1;
    clk1();
    for (int i = 0; i < 8; i++) write(3'(i), 8'(8'h11 * (i + 1)));
    frame();
    chk("t1_window", data, 32'h44332211);

    // 2. two enabled frames -> step to pos 1, next frame shows it
    enable = 1'b1;
    frame();
    frame();
    chk("t2_pos1", {29'd0, pos}, 32'd1);
    frame();
    chk("t2_window", data, 32'h55443322);

    // 3. advance across the wrap, dwell at 0
    run_to(3'd6);
    frame();
    chk("t3_win6", data, 32'h22118877);
    run_to(3'd7);
    frame();
    chk("t3_win7", data, 32'h33221188);
    run_to(3'd0);
    frame(); frame();
    chk("t3_dwell_pos", {29'd0, pos}, 32'd0);
    frame(); frame();
    chk("t3_after_dwell", {29'd0, pos}, 32'd1);

    // 4. write coincident with frame_tick is seen only next frame
    run_to(3'd0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_col = 8'hFF;
    frame();
    chk("t4_old_col", {24'd0, data[7:0]}, 32'h11);
    frame();
    chk("t4_new_col", {24'd0, data[7:0]}, 32'hFF);

    // 5. restart beats a coincident step; frozen while disabled; then dwell
    run_to(3'd3);
    frame();
    restart = 1'b1;
    frame();
    chk("t5_restart_pos", {29'd0, pos}, 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) frame();
    chk("t5_frozen_pos", {29'd0, pos}, 32'd0);
    enable = 1'b1;
    frame(); frame();
    chk("t5_dwell_hold", {29'd0, pos}, 32'd0);
    frame(); frame();
    chk("t5_dwell_exit", {29'd0, pos}, 32'd1);

    // mid-run reset overrides a coincident write
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_col = 8'h5A;
    clk1();
    model_reset();
    chk("mrst_data", data, 32'h0);
    chk("mrst_pos", {29'd0, pos}, 32'd0);
    rst_n = 1'b1;
    enable = 1'b0;
    frame();
    chk("mrst_buf", data, 32'h0);

`ifdef MATRIX_SCROLLER_DIR_EN
    // 6. reverse stepping from pos 0 after dwell
    for (int i = 0; i < 8; i++) write(3'(i), 8'(8'h11 * (i + 1)));
    enable = 1'b1; dir = 1'b1;
    restart = 1'b1;
    frame();
    frame(); frame();
    frame(); frame();
    chk("t6_pos7", {29'd0, pos}, 32'd7);
    frame();
    chk("t6_win7", data, 32'h33221188);
    frame();
    chk("t6_pos6", {29'd0, pos}, 32'd6);
    frame();
    chk("t6_win6", data, 32'h22118877);
    run_to(3'd0);
    frame(); frame();
    chk("t6_rev_dwell", {29'd0, pos}, 32'd0);
`endif

    if (exp_q.size() != 0) begin
      compared++; mismatched++;
      $error("FAIL sb_left: observed %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
